viterbi_traceback: RTL and testbench
====================================

Name: viterbi_traceback

Overview:
- Traceback unit of the Viterbi decoder, directly downstream of the trellis-diagram memory.
- Once the trellis memory reports full, it walks the stored survivor (previous-state) columns backwards from a chosen start state, one column per cycle, and extracts one decoded bit per column.
- Decoded bits are produced newest-first, so they are held in an internal LIFO. They are then emitted oldest-first to the output stage under a valid/ready handshake.

Parameters:
- STATE_REG_NUM, 8, width of a state index (max K-1).
- STATE_NUM, 256, number of trellis states (2**STATE_REG_NUM).
- TB_DEPTH, 45, traceback depth; equals the trellis memory column count and the LIFO depth.
- CNT_W, 6, width of the column/LIFO counters; must satisfy 2**CNT_W > TB_DEPTH.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-low reset.
- en_tb  input  1  block enable; when low, all state is held and no outputs change except o_valid, which is forced to 0.
- i_bck_prv_st  input  STATE_REG_NUM x STATE_NUM  unpacked array; current trellis column (previous state per state).
- i_td_full  input  1  trellis memory full; start of traceback.
- i_td_empty  input  1  trellis memory is presenting its last column (column 0).
- i_start_st  input  STATE_REG_NUM  start state (best path metric from the ACS stage); sampled on the start event.
- i_st_bits  input  4  active state bits (K-1), legal range 2..STATE_REG_NUM; sampled on the start event.
- i_out_rdy  input  1  downstream ready.
- o_data  output  1  decoded bit.
- o_valid  output  1  o_data is valid.
- o_done  output  1  one-cycle pulse after the last bit of a block is accepted.
- o_tb_busy  output  1  high in TRACE or OUTPUT; the controller holds off en_td while it is high.
- o_err  output  1  sticky flag: i_td_full seen while busy.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cur_st=0; lifo_cnt=0; LIFO contents=0; o_data=0, o_valid=0, o_done=0, o_tb_busy=0, o_err=0. Reset mid-operation discards any partial block.
- Start event: IDLE and en_tb=1 and i_td_full=1.
- FSM states: IDLE, TRACE, OUTPUT. All transitions are qualified by en_tb=1.
- IDLE:
  - On the start event: cur_st <= i_start_st masked to i_st_bits bits; latch i_st_bits; lifo_cnt <= 0; go to TRACE.
  - i_bck_prv_st is ignored in IDLE.
- TRACE, each enabled cycle:
  - push cur_st[st_bits-1] into LIFO[lifo_cnt]; lifo_cnt++.
  - cur_st <= i_bck_prv_st[cur_st], masked to st_bits.
  - The trellis memory decrements its column pointer on the same edge, so one column is consumed per cycle with zero added latency.
- TRACE exit:
  - If i_td_empty=1, or the push just made lifo_cnt==TB_DEPTH, go to OUTPUT after this cycle's push.
  - If i_td_empty=1 on the very first TRACE cycle, exactly one bit is pushed.
- OUTPUT:
  - o_valid=1 and o_data=LIFO[lifo_cnt-1], driven from registers.
  - On i_out_rdy=1 with o_valid=1: pop, lifo_cnt--.
  - When the pop empties the LIFO (lifo_cnt 1->0): o_valid deasserts next cycle, o_done=1 for exactly that next cycle, state -> IDLE.
  - While i_out_rdy=0: o_data and o_valid hold steady.
- Output order: the first bit emitted is the bit pushed last (the oldest trellis column).
- Throughput: a block of N columns takes N TRACE cycles, then N output cycles with ready held high. The first o_valid appears 1 cycle after the last TRACE cycle.
- o_tb_busy: registered; equals (state != IDLE).
- o_err: set when i_td_full=1 while state != IDLE and en_tb=1. The new block is ignored. Cleared only by reset.
- Simultaneous events:
  - Start event coinciding with o_done's cycle: accepted, since state is already IDLE.
  - i_td_empty in IDLE: ignored.
- Out-of-range i_st_bits: values >STATE_REG_NUM clamp to STATE_REG_NUM; values <2 clamp to 2.
- en_tb=0: FSM, counters and LIFO frozen; o_valid=0; no pop occurs.

Test Plan:
- Identity trellis (prv_st[i]=i), i_start_st=8'h80, i_st_bits=8, 45 columns with empty on the 45th, ready=1 -> 45 bits, all 1; o_done pulses one cycle after the 45th bit; o_tb_busy low afterwards.
- K=3 (i_st_bits=2), trellis encoding input sequence 1,0,1,1,0,0 (6 columns, empty on the 6th), start state 0 -> output 1,0,1,1,0,0 in forward order.
- Same as the previous test with i_out_rdy toggled 1,0,0,1,... -> o_data/o_valid stable while ready=0; exactly 6 transfers; no duplicate or missing bits.
- i_td_full asserted again mid-TRACE -> o_err=1 and stays 1; the current block completes unchanged.
- rst pulsed low mid-OUTPUT with 20 bits pending -> all outputs 0 immediately; after release, a new full starts a clean block of correct length.
- en_tb held low for 5 cycles mid-TRACE -> count and cur_st frozen; the final output is identical to the uninterrupted run.

Source files
------------

// File: rtl/viterbi_traceback_if.sv
// Traceback port bundle: trellis column in, decoded bit stream out.
//   master : the trellis memory / controller / output-stage side
//   slave  : the traceback unit
//   en_tb        block enable
//   i_bck_prv_st current trellis column (previous state per state)
//   i_td_full    trellis memory full, starts a traceback
//   i_td_empty   trellis memory presenting its last column
//   i_start_st   start state, i_st_bits active state bits
//   i_out_rdy    downstream ready
//   o_data/o_valid decoded bit stream, o_done block-complete pulse
//   o_tb_busy    traceback or output in progress, o_err sticky overrun flag
interface viterbi_traceback_if #(
    parameter int unsigned STATE_REG_NUM = 8,
    parameter int unsigned STATE_NUM     = 256
);
    logic                     en_tb;
    logic [STATE_REG_NUM-1:0] i_bck_prv_st [STATE_NUM];
    logic                     i_td_full;
    logic                     i_td_empty;
    logic [STATE_REG_NUM-1:0] i_start_st;
    logic [3:0]               i_st_bits;
    logic                     i_out_rdy;
    logic                     o_data;
    logic                     o_valid;
    logic                     o_done;
    logic                     o_tb_busy;
    logic                     o_err;

    modport master (
        output en_tb, i_bck_prv_st, i_td_full, i_td_empty, i_start_st, i_st_bits, i_out_rdy,
        input  o_data, o_valid, o_done, o_tb_busy, o_err
    );

    modport slave (
        input  en_tb, i_bck_prv_st, i_td_full, i_td_empty, i_start_st, i_st_bits, i_out_rdy,
        output o_data, o_valid, o_done, o_tb_busy, o_err
    );
endinterface

// File: rtl/viterbi_traceback.sv
// Viterbi traceback: walks survivor columns backwards from a start state,
// one column per enabled cycle, pushing one decoded bit per column into a
// LIFO, then emits the bits oldest-first under valid/ready.
//   clk, rst (async, active-low)
//   tb_if : slave view of viterbi_traceback_if (see interface header)
module viterbi_traceback #(
    parameter int unsigned STATE_REG_NUM = 8,
    parameter int unsigned STATE_NUM     = 256,
    parameter int unsigned TB_DEPTH      = 45,
    parameter int unsigned CNT_W         = 6
) (
    input logic                clk,
    input logic                rst,
    viterbi_traceback_if.slave tb_if
);
    localparam int unsigned BITS_W = 4;
    localparam int unsigned IDX_W  = $clog2(STATE_REG_NUM);
    localparam logic [BITS_W-1:0] MAX_BITS = BITS_W'(STATE_REG_NUM);
    localparam logic [BITS_W-1:0] MIN_BITS = BITS_W'(2);

    // Elaboration-time parameter sanity
    if (STATE_NUM != (1 << STATE_REG_NUM)) begin : g_bad_state_num
        $error("STATE_NUM must equal 2**STATE_REG_NUM");
    end
    if ((1 << CNT_W) <= TB_DEPTH) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TB_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRACE  = 2'd1,
        S_OUTPUT = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [STATE_REG_NUM-1:0] cur_st_q, cur_st_d;
    logic [BITS_W-1:0]        st_bits_q, st_bits_d;
    logic [CNT_W-1:0]         lifo_cnt_q, lifo_cnt_d;
    logic [TB_DEPTH-1:0]      lifo_q, lifo_d;
    logic                     data_q, data_d;
    logic                     valid_q, valid_d;
    logic                     done_q, done_d;
    logic                     busy_q, busy_d;
    logic                     err_q, err_d;

    logic                     en;
    logic [BITS_W-1:0]        st_bits_in;
    logic [IDX_W-1:0]         msb_idx;
    logic                     push_bit;
    logic [STATE_REG_NUM-1:0] nxt_st;
    logic                     last_push;
    logic                     pop;
    logic                     last_pop;

    // Low-order mask of 'bits' ones; computed one bit wider so bits==STATE_REG_NUM works
    function automatic logic [STATE_REG_NUM-1:0] mask_f(input logic [BITS_W-1:0] bits);
        logic [STATE_REG_NUM:0] one_hot;
        one_hot = (STATE_REG_NUM + 1)'(1) << bits;
        return STATE_REG_NUM'(one_hot - (STATE_REG_NUM + 1)'(1));
    endfunction

    // Shared decode of the current cycle's events
    always_comb begin
        en = tb_if.en_tb;
        if (tb_if.i_st_bits > MAX_BITS) begin
            st_bits_in = MAX_BITS;
        end else if (tb_if.i_st_bits < MIN_BITS) begin
            st_bits_in = MIN_BITS;
        end else begin
            st_bits_in = tb_if.i_st_bits;
        end
        msb_idx   = IDX_W'(st_bits_q - BITS_W'(1));
        push_bit  = cur_st_q[msb_idx];
        nxt_st    = tb_if.i_bck_prv_st[cur_st_q] & mask_f(st_bits_q);
        last_push = tb_if.i_td_empty || (lifo_cnt_q == CNT_W'(TB_DEPTH - 1));
        pop       = (state_q == S_OUTPUT) && valid_q && en && tb_if.i_out_rdy;
        last_pop  = pop && (lifo_cnt_q == CNT_W'(1));
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cur_st_q   <= '0;
            st_bits_q  <= MIN_BITS;
            lifo_cnt_q <= '0;
            lifo_q     <= '0;
            data_q     <= 1'b0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_st_q   <= cur_st_d;
            st_bits_q  <= st_bits_d;
            lifo_cnt_q <= lifo_cnt_d;
            lifo_q     <= lifo_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                S_IDLE:   if (tb_if.i_td_full) state_d = S_TRACE;
                S_TRACE:  if (last_push)       state_d = S_OUTPUT;
                S_OUTPUT: if (last_pop)        state_d = S_IDLE;
                default:                       state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values; everything holds while en_tb is low
    always_comb begin
        cur_st_d   = cur_st_q;
        st_bits_d  = st_bits_q;
        lifo_cnt_d = lifo_cnt_q;
        lifo_d     = lifo_q;
        data_d     = data_q;
        valid_d    = valid_q;
        done_d     = done_q;
        busy_d     = busy_q;
        err_d      = err_q;
        if (en) begin
            done_d = 1'b0;
            busy_d = (state_d != S_IDLE);
            if (tb_if.i_td_full && (state_q != S_IDLE)) begin
                err_d = 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tb_if.i_td_full) begin
                        st_bits_d  = st_bits_in;
                        cur_st_d   = tb_if.i_start_st & mask_f(st_bits_in);
                        lifo_cnt_d = '0;
                    end
                end
                S_TRACE: begin
                    lifo_d[lifo_cnt_q] = push_bit;
                    lifo_cnt_d         = lifo_cnt_q + CNT_W'(1);
                    cur_st_d           = nxt_st;
                    // The bit just pushed is the LIFO top, so present it directly
                    if (last_push) begin
                        valid_d = 1'b1;
                        data_d  = push_bit;
                    end
                end
                S_OUTPUT: begin
                    if (pop) begin
                        lifo_cnt_d = lifo_cnt_q - CNT_W'(1);
                        if (last_pop) begin
                            valid_d = 1'b0;
                            data_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            data_d = lifo_q[lifo_cnt_q - CNT_W'(2)];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign tb_if.o_data    = data_q;
    assign tb_if.o_valid   = valid_q & en;
    assign tb_if.o_done    = done_q;
    assign tb_if.o_tb_busy = busy_q;
    assign tb_if.o_err     = err_q;
endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback: models the trellis memory column
// pointer and checks decoded streams against hand-computed vectors.
module tb_viterbi_traceback;
    logic clk;
    logic rst;

    viterbi_traceback_if #(.STATE_REG_NUM(8), .STATE_NUM(256)) tb_if ();

    viterbi_traceback #(
        .STATE_REG_NUM(8),
        .STATE_NUM(256),
        .TB_DEPTH(45),
        .CNT_W(6)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .tb_if(tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          mode;      // 0 identity, 1 K=3 path, 2 K=3 path with junk upper bits
        int          n;         // columns held by the trellis memory
        logic [7:0]  start;
        logic [3:0]  bits;
        int          rdy_mode;  // 0 always ready, 1 ready pattern 1,0,0
        int          gap_at;    // column index where en_tb drops for 5 cycles, -1 none
        int          full_at;   // column index where i_td_full re-asserts, -1 none
        int          exp_len;
        logic [63:0] exp_bits;  // bit k = k-th emitted bit
        logic        exp_err;
    } vec_t;

    vec_t       vecs[12];
    logic [7:0] path[7];
    int         n_chk;
    int         n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Present trellis column j (j=0 is the newest column)
    task automatic set_col(input int mode, input int j);
        logic [7:0] junk;
        int t;
        junk = (mode == 2) ? 8'hA0 : 8'h00;
        for (int i = 0; i < 256; i++) begin
            if (mode == 0) tb_if.i_bck_prv_st[i] = 8'(i);
            else           tb_if.i_bck_prv_st[i] = 8'((i + 1) % 4) | junk;
        end
        if (mode != 0 && j < 6) begin
            t = 6 - j;
            tb_if.i_bck_prv_st[path[t]] = path[t-1] | junk;
        end
    endtask

    task automatic do_trace(input vec_t v, output int tcyc);
        int  j;
        int  cyc;
        tb_if.i_st_bits  = v.bits;
        tb_if.i_start_st = v.start;
        tb_if.i_td_empty = 1'b0;
        tb_if.en_tb      = 1'b1;
        tb_if.i_td_full  = 1'b1;
        @(posedge clk); #1;
        tb_if.i_td_full = 1'b0;
        j = 0; tcyc = 0; cyc = 0;
        while (!tb_if.o_valid && cyc < 300) begin
            set_col(v.mode, j);
            tb_if.i_td_empty = (j == v.n - 1);
            tb_if.i_td_full  = 1'b0;
            if (j == v.gap_at && tcyc == j) begin
                tb_if.en_tb = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("gap_valid_low", 64'(tb_if.o_valid), 64'd0);
                    chk("gap_busy_held", 64'(tb_if.o_tb_busy), 64'd1);
                end
                tb_if.en_tb = 1'b1;
            end
            tb_if.i_td_full = (j == v.full_at);
            @(posedge clk); #1;
            j++; tcyc++; cyc++;
        end
        tb_if.i_td_full  = 1'b0;
        tb_if.i_td_empty = 1'b0;
        if (cyc >= 300) chk("trace_timeout", 64'(cyc), 64'd0);
    endtask

    task automatic do_output(input int max_pops, input int rdy_mode,
                             output logic [63:0] got, output int npop);
        int   cyc;
        logic stalled;
        logic pd;
        npop = 0; cyc = 0; stalled = 1'b0; pd = 1'b0; got = '0;
        while (npop < max_pops && cyc < 400) begin
            tb_if.i_out_rdy = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            @(negedge clk);
            if (stalled) begin
                chk("hold_valid", 64'(tb_if.o_valid), 64'd1);
                chk("hold_data", 64'(tb_if.o_data), 64'(pd));
            end
            if (tb_if.o_valid && tb_if.i_out_rdy) begin
                got[npop] = tb_if.o_data;
                npop++;
                stalled = 1'b0;
            end else begin
                stalled = tb_if.o_valid;
                pd      = tb_if.o_data;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (cyc >= 400) chk("output_timeout", 64'(cyc), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input bit b2b);
        int          tcyc;
        int          npop;
        logic [63:0] got;
        do_trace(v, tcyc);
        chk("trace_cycles", 64'(tcyc), 64'(v.exp_len));
        do_output(v.exp_len, v.rdy_mode, got, npop);
        chk("out_bits", got, v.exp_bits);
        chk("out_count", 64'(npop), 64'(v.exp_len));
        chk("done_pulse", 64'(tb_if.o_done), 64'd1);
        chk("valid_after", 64'(tb_if.o_valid), 64'd0);
        chk("busy_after", 64'(tb_if.o_tb_busy), 64'd0);
        chk("err_flag", 64'(tb_if.o_err), 64'(v.exp_err));
        tb_if.i_out_rdy = 1'b0;
        if (!b2b) begin
            @(posedge clk); #1;
            chk("done_single", 64'(tb_if.o_done), 64'd0);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          tcyc;
        int          npop;
        logic [63:0] got;

        n_chk = 0;
        n_err = 0;
        // Encoder path for inputs 1,0,1,1,0,0 with state' = {u, s[1]}
        path = '{8'd0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd1, 8'd0};

        vecs[0]  = '{0, 45, 8'h80, 4'd8,  0, -1, -1, 45, 64'h1FFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{1,  6, 8'h00, 4'd2,  0, -1, -1,  6, 64'h0D,             1'b0};
        vecs[2]  = '{1,  6, 8'h00, 4'd2,  1, -1, -1,  6, 64'h0D,             1'b0};
        vecs[3]  = '{2,  6, 8'hFC, 4'd2,  0, -1, -1,  6, 64'h0D,             1'b0};
        vecs[4]  = '{1,  6, 8'h00, 4'd2,  0,  3, -1,  6, 64'h0D,             1'b0};
        vecs[5]  = '{0, 50, 8'h80, 4'd8,  0, -1, -1, 45, 64'h1FFF_FFFF_FFFF, 1'b0};
        vecs[6]  = '{0,  1, 8'h80, 4'd8,  0, -1, -1,  1, 64'h1,              1'b0};
        vecs[7]  = '{0,  5, 8'h02, 4'd1,  0, -1, -1,  5, 64'h1F,             1'b0};
        vecs[8]  = '{0,  5, 8'h38, 4'd4,  0, -1, -1,  5, 64'h1F,             1'b0};
        vecs[9]  = '{0,  5, 8'h07, 4'd4,  0, -1, -1,  5, 64'h00,             1'b0};
        vecs[10] = '{0,  5, 8'h80, 4'd15, 0, -1, -1,  5, 64'h1F,             1'b0};
        vecs[11] = '{1,  6, 8'h00, 4'd2,  1,  3,  2,  6, 64'h0D,             1'b1};

        rst              = 1'b0;
        tb_if.en_tb      = 1'b0;
        tb_if.i_td_full  = 1'b0;
        tb_if.i_td_empty = 1'b0;
        tb_if.i_start_st = '0;
        tb_if.i_st_bits  = '0;
        tb_if.i_out_rdy  = 1'b0;
        set_col(0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(tb_if.o_valid), 64'd0);
        chk("rst_data", 64'(tb_if.o_data), 64'd0);
        chk("rst_done", 64'(tb_if.o_done), 64'd0);
        chk("rst_busy", 64'(tb_if.o_tb_busy), 64'd0);
        chk("rst_err", 64'(tb_if.o_err), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], 1'b0);
        end

        // Reset in the middle of OUTPUT with 20 bits still pending
        do_trace(vecs[0], tcyc);
        do_output(25, 0, got, npop);
        chk("pre_rst_count", 64'(npop), 64'd25);
        chk("pre_rst_valid", 64'(tb_if.o_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valid", 64'(tb_if.o_valid), 64'd0);
        chk("midrst_data", 64'(tb_if.o_data), 64'd0);
        chk("midrst_busy", 64'(tb_if.o_tb_busy), 64'd0);
        chk("midrst_done", 64'(tb_if.o_done), 64'd0);
        chk("midrst_err", 64'(tb_if.o_err), 64'd0);
        tb_if.i_out_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_busy", 64'(tb_if.o_tb_busy), 64'd0);
        run_vec(vecs[1], 1'b0);

        // New start in the same cycle as o_done
        run_vec(vecs[1], 1'b1);
        run_vec(vecs[3], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
